lcd_text_receiver: RTL and testbench
====================================

LCD_TEXT_RECEIVER -- requirements
Module: lcd_text_receiver

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 16: characters per display line.
REQ-002 SHALL have parameter FREQ, default 50000000: CLK frequency in Hz.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port LCD_D  input  5  bit 4 = RS, bits 3:0 = data nibble; asynchronous to CLK.
REQ-006 SHALL have port LCD_E  input  1  LCD enable strobe; asynchronous to CLK.
REQ-007 SHALL have port line1  output  8*LINE_LENGTH  line-1 character buffer; column 0 in bits [8*LINE_LENGTH-1 -: 8].
REQ-008 SHALL have port line2  output  8*LINE_LENGTH  line-2 character buffer; same packing as line1.
REQ-009 SHALL have port byte_valid  output  1  one-cycle pulse when a byte is assembled.
REQ-010 SHALL have port byte_out  output  8  last assembled byte; held until the next byte_valid.
REQ-011 SHALL have port byte_rs  output  1  RS of the last assembled byte.
REQ-012 SHALL have port text_done  output  1  one-cycle pulse when line2 column LINE_LENGTH-1 is written.
REQ-013 SHALL have port sync_error  output  1  one-cycle pulse on RS mismatch or nibble timeout.

Function
REQ-014 SHALL pass LCD_E and LCD_D through 2-flop synchronizers, then detect the falling edge of synchronized LCD_E.
REQ-015 SHALL sample synchronized LCD_D in the same cycle the falling edge is detected.
REQ-016 SHALL run a nibble FSM with states WAIT_HIGH and WAIT_LOW.
- WAIT_HIGH + fall: store nibble as bits 7:4 and RS; go to WAIT_LOW.
- WAIT_LOW + fall: assemble byte; go to WAIT_HIGH.
REQ-017 SHALL, in WAIT_LOW, compare the low-nibble RS with the stored RS.
- On mismatch: discard the byte, pulse sync_error, go to WAIT_HIGH.
- No byte_valid is generated for a discarded byte.
REQ-018 SHALL pulse byte_valid exactly 1 cycle after the cycle in which the second falling edge is detected, with byte_out/byte_rs valid in that same cycle.
- Total latency: 4 CLK from the first rising CLK edge that sees LCD_E low at the pin.
REQ-019 SHALL keep a cursor {line, col, valid}.
REQ-020 SHALL handle RS=0, byte[7]=1 (set DDRAM address) as follows:
- addr 0x00..LINE_LENGTH-1: cursor = line1, col = addr, valid.
- addr 0x40..0x40+LINE_LENGTH-1: cursor = line2, col = addr-0x40, valid.
- Any other addr: cursor valid = 0.
REQ-021 SHALL handle RS=0, byte=0x01 (clear) by writing 0x20 to every column of both lines in one cycle and setting the cursor to line1 col 0, valid.
REQ-022 SHALL ignore all other RS=0 bytes except for byte_valid reporting.
REQ-023 SHALL handle RS=1 with a valid cursor by writing the byte to the cursor column of the cursor line, then incrementing col.
- After col LINE_LENGTH-1 is written, cursor valid = 0 (no wrap).
REQ-024 SHALL drop RS=1 bytes while the cursor is invalid; byte_valid still pulses.
REQ-025 SHALL pulse text_done in the same cycle as byte_valid for an RS=1 write to line2 col LINE_LENGTH-1.
REQ-026 SHALL update a buffer write on the cycle byte_valid is asserted, visible on line1/line2 the next cycle.
REQ-027 SHALL, when a falling edge coincides with a timeout expiry, process the edge as WAIT_HIGH (timeout wins first, edge becomes the new high nibble).

Reset
REQ-028 SHALL, on RESET, immediately clear state as follows:
- FSM = WAIT_HIGH; synchronizers = 0.
- All line1/line2 characters = 0x20; cursor = line1 col 0 valid.
- byte_valid = text_done = sync_error = 0; byte_out = 0x00; byte_rs = 0.
REQ-029 SHALL discard a half-received byte when reset is asserted mid-byte; the first fall after release is a high nibble.

Configuration
REQ-030 SHALL compile a nibble timeout when macro LCD_RX_TIMEOUT_EN is defined.
- Counter starts on entry to WAIT_LOW.
- If no falling edge occurs within FREQ/10000 CLK (100 us; 5000 cycles at default), return to WAIT_HIGH and pulse sync_error.
REQ-031 SHALL, without LCD_RX_TIMEOUT_EN, remain in WAIT_LOW indefinitely and contain no timeout counter.

Verification
REQ-032 SHALL cover: nibbles RS=0 0x8,0x5 -> byte_valid, byte_out=0x85, cursor line1 col 5; then RS=1 0x4,0x1 -> line1 col 5 = 0x41.
REQ-033 SHALL cover: set address 0xC0, then 16 RS=1 bytes 0x30..0x3F -> line2 = "0123456789:;<=>?" and text_done on the 16th byte only.
REQ-034 SHALL cover: high nibble RS=1, low nibble RS=0 -> sync_error pulse, no byte_valid; next valid pair is assembled correctly.
REQ-035 SHALL cover: command 0x01 after text is written -> both lines all 0x20, cursor line1 col 0.
REQ-036 SHALL cover: RESET asserted between nibbles -> outputs at reset values; next pair 0x4,0x2 with RS=1 -> line1 col 0 = 0x42.
REQ-037 SHALL cover, with LCD_RX_TIMEOUT_EN: a single nibble, then idle 5000 cycles -> sync_error; next pair assembles as a new byte.

Source files
------------

// File: rtl/lcd_text_receiver.sv
// rtl/lcd_text_receiver.sv - snoops a 4-bit HD44780-style LCD bus and rebuilds both text lines
// Optional nibble timeout is compiled in when LCD_RX_TIMEOUT_EN is defined.
module lcd_text_receiver #(
  parameter int LINE_LENGTH = 16,
  parameter int FREQ        = 50000000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [4:0]               LCD_D,
  input  logic                     LCD_E,
  output logic [8*LINE_LENGTH-1:0] line1,
  output logic [8*LINE_LENGTH-1:0] line2,
  output logic                     byte_valid,
  output logic [7:0]               byte_out,
  output logic                     byte_rs,
  output logic                     text_done,
  output logic                     sync_error
);

  typedef enum logic {WAIT_HIGH, WAIT_LOW} state_t;

  localparam int              CW         = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [CW-1:0]   LAST_COL   = CW'(LINE_LENGTH - 1);
  localparam logic [6:0]      LEN7       = 7'(LINE_LENGTH);
  // 100 us worth of clocks; clamped so a tiny FREQ still yields a usable window
  localparam int              TMO_CYCLES = (FREQ / 10000 > 0) ? FREQ / 10000 : 1;

  logic           e_s1, e_s2, e_d;
  logic [4:0]     d_s1, d_s2;
  logic           fall_q;
  logic [4:0]     nib_q;
  state_t         state, state_n;
  logic [3:0]     hi_nib;
  logic           hi_rs;
  logic           hi_load, asm_ok, err, tmo_hit;
  logic           cur_line;
  logic [CW-1:0]  cur_col;
  logic           cur_valid;
  logic [7:0]     l1_mem [LINE_LENGTH];
  logic [7:0]     l2_mem [LINE_LENGTH];
  logic [6:0]     addr, addr_off;
  logic           in_l1, in_l2;

  // Two-flop synchronizers for the asynchronous bus, plus one extra E stage for edge detection
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      e_s1 <= 1'b0;
      e_s2 <= 1'b0;
      e_d  <= 1'b0;
      d_s1 <= '0;
      d_s2 <= '0;
    end else begin
      e_s1 <= LCD_E;
      e_s2 <= e_s1;
      e_d  <= e_s2;
      d_s1 <= LCD_D;
      d_s2 <= d_s1;
    end
  end

  // Register the falling-edge strobe together with the data sampled in that same cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fall_q <= 1'b0;
      nib_q  <= '0;
    end else begin
      fall_q <= e_d & ~e_s2;
      nib_q  <= d_s2;
    end
  end

  // Nibble FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= WAIT_HIGH;
    else       state <= state_n;
  end

  // Nibble FSM: a timeout takes priority, and a coincident edge restarts as a fresh high nibble
  always_comb begin
    state_n = state;
    hi_load = 1'b0;
    asm_ok  = 1'b0;
    err     = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (fall_q) begin
          hi_load = 1'b1;
          state_n = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (tmo_hit) begin
          err = 1'b1;
          if (fall_q) hi_load = 1'b1;
          else        state_n = WAIT_HIGH;
        end else if (fall_q) begin
          state_n = WAIT_HIGH;
          if (nib_q[4] == hi_rs) asm_ok = 1'b1;
          else                   err    = 1'b1;
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  // Hold the high nibble and its RS until the low nibble arrives
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hi_nib <= '0;
      hi_rs  <= 1'b0;
    end else if (hi_load) begin
      hi_nib <= nib_q[3:0];
      hi_rs  <= nib_q[4];
    end
  end

`ifdef LCD_RX_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Count cycles spent waiting for the low nibble; restarts whenever a high nibble is taken
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                tmo_cnt <= '0;
    else if (hi_load)                         tmo_cnt <= '0;
    else if (state == WAIT_LOW && !tmo_hit)   tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo_hit = (state == WAIT_LOW) && (tmo_cnt == 32'(TMO_CYCLES - 1));
`else
  // Without the timeout the FSM waits for the low nibble forever
  assign tmo_hit = (TMO_CYCLES == 0);
`endif

  // Byte report registers: pulses last one cycle, byte_out/byte_rs hold until the next byte
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      byte_rs    <= 1'b0;
      text_done  <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      byte_valid <= asm_ok;
      sync_error <= err;
      text_done  <= asm_ok & hi_rs & cur_valid & cur_line & (cur_col == LAST_COL);
      if (asm_ok) begin
        byte_out <= {hi_nib, nib_q[3:0]};
        byte_rs  <= hi_rs;
      end
    end
  end

  assign addr     = byte_out[6:0];
  assign addr_off = addr - 7'h40;
  assign in_l1    = (addr < LEN7);
  assign in_l2    = (addr >= 7'h40) && (addr_off < LEN7);

  // Apply the reported byte to the cursor and character buffers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cur_line  <= 1'b0;
      cur_col   <= '0;
      cur_valid <= 1'b1;
      for (int i = 0; i < LINE_LENGTH; i++) begin
        l1_mem[i] <= 8'h20;
        l2_mem[i] <= 8'h20;
      end
    end else if (byte_valid) begin
      if (!byte_rs) begin
        if (byte_out[7]) begin
          if (in_l1) begin
            cur_line  <= 1'b0;
            cur_col   <= addr[CW-1:0];
            cur_valid <= 1'b1;
          end else if (in_l2) begin
            cur_line  <= 1'b1;
            cur_col   <= addr_off[CW-1:0];
            cur_valid <= 1'b1;
          end else begin
            cur_valid <= 1'b0;
          end
        end else if (byte_out == 8'h01) begin
          cur_line  <= 1'b0;
          cur_col   <= '0;
          cur_valid <= 1'b1;
          for (int i = 0; i < LINE_LENGTH; i++) begin
            l1_mem[i] <= 8'h20;
            l2_mem[i] <= 8'h20;
          end
        end
      end else if (cur_valid) begin
        if (cur_line) l2_mem[cur_col] <= byte_out;
        else          l1_mem[cur_col] <= byte_out;
        if (cur_col == LAST_COL) cur_valid <= 1'b0;
        else                     cur_col   <= cur_col + 1'b1;
      end
    end
  end

  // Column 0 sits in the most significant byte of each line bus
  for (genvar g = 0; g < LINE_LENGTH; g++) begin : g_pack
    assign line1[8*(LINE_LENGTH-g)-1 -: 8] = l1_mem[g];
    assign line2[8*(LINE_LENGTH-g)-1 -: 8] = l2_mem[g];
  end

endmodule

// File: tb/tb_lcd_text_receiver.sv
// tb/tb_lcd_text_receiver.sv - scoreboard bench for lcd_text_receiver
module tb_lcd_text_receiver;
  localparam int LL = 16;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [4:0]      LCD_D = 5'h00;
  logic            LCD_E = 1'b0;
  logic [8*LL-1:0] line1, line2;
  logic            byte_valid;
  logic [7:0]      byte_out;
  logic            byte_rs, text_done, sync_error;

  lcd_text_receiver #(.LINE_LENGTH(LL), .FREQ(50000000)) dut (
    .CLK(CLK), .RESET(RESET), .LCD_D(LCD_D), .LCD_E(LCD_E),
    .line1(line1), .line2(line2), .byte_valid(byte_valid), .byte_out(byte_out),
    .byte_rs(byte_rs), .text_done(text_done), .sync_error(sync_error)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       is_err;
    logic [7:0] b;
    logic       rs;
    logic       td;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] m1 [LL];
  logic [7:0] m2 [LL];
  int         m_line, m_col;
  bit         m_ok;

  function automatic void model_reset();
    for (int c = 0; c < LL; c++) begin
      m1[c] = 8'h20;
      m2[c] = 8'h20;
    end
    m_line = 0; m_col = 0; m_ok = 1'b1;
  endfunction

  // Display semantics of one byte; returns whether it completes line 2
  function automatic logic model_byte(input logic rs, input logic [7:0] b);
    logic td;
    int   a;
    td = 1'b0;
    if (!rs) begin
      if (b >= 8'h80) begin
        a = int'(b) - 128;
        if (a < LL) begin m_line = 0; m_col = a; m_ok = 1'b1; end
        else if (a >= 64 && a < 64 + LL) begin m_line = 1; m_col = a - 64; m_ok = 1'b1; end
        else m_ok = 1'b0;
      end else if (b == 8'h01) begin
        model_reset();
      end
    end else if (m_ok) begin
      if (m_line == 0) m1[m_col] = b;
      else             m2[m_col] = b;
      td = (m_line == 1 && m_col == LL - 1);
      m_col++;
      if (m_col == LL) m_ok = 1'b0;
    end
    return td;
  endfunction

  task automatic send_nibble(input logic rs, input logic [3:0] n);
    LCD_D = {rs, n};
    LCD_E = 1'b1;
    repeat (3) @(negedge CLK);
    LCD_E = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic send_pair(input logic rh, input logic [3:0] h, input logic rl, input logic [3:0] l);
    ev_t e;
    if (rh != rl) e = '{1'b1, 8'h00, 1'b0, 1'b0};
    else          e = '{1'b0, {h, l}, rh, model_byte(rh, {h, l})};
    exp_q.push_back(e);
    send_nibble(rh, h);
    send_nibble(rl, l);
    repeat (4) @(negedge CLK);
  endtask

  task automatic check_lines(input string tag);
    logic [8*LL-1:0] e1, e2;
    for (int c = 0; c < LL; c++) begin
      e1[8*(LL-c)-1 -: 8] = m1[c];
      e2[8*(LL-c)-1 -: 8] = m2[c];
    end
    vectors++;
    if (line1 !== e1) begin
      miscompares++;
      $display("FAIL %s line1 got %h want %h", tag, line1, e1);
    end
    vectors++;
    if (line2 !== e2) begin
      miscompares++;
      $display("FAIL %s line2 got %h want %h", tag, line2, e2);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    vectors++;
    if ({byte_valid, text_done, sync_error, byte_rs, byte_out} !== 12'h000) begin
      miscompares++;
      $display("FAIL %s outs got v=%b td=%b se=%b rs=%b b=%h want all zero",
               tag, byte_valid, text_done, sync_error, byte_rs, byte_out);
    end
    check_lines(tag);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge CLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain got %0d pending want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every reported byte or error is matched against the next expected event
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      if (byte_valid || sync_error) begin
        ev_t e;
        bit  ok;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event got v=%b se=%b b=%h want none", byte_valid, sync_error, byte_out);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) ok = sync_error && !byte_valid && !text_done;
          else          ok = byte_valid && !sync_error && byte_out == e.b && byte_rs == e.rs && text_done == e.td;
          if (!ok) begin
            miscompares++;
            $display("FAIL event got v=%b se=%b b=%h rs=%b td=%b want err=%b b=%h rs=%b td=%b",
                     byte_valid, sync_error, byte_out, byte_rs, text_done, e.is_err, e.b, e.rs, e.td);
          end
        end
      end else if (text_done) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_text_done got 1 want 0");
      end
    end
  end

  initial begin
    int         lat;
    int         r;
    logic [7:0] b;
    logic       rh;

    RESET = 1'b0;
    #1 RESET = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_outs("reset_state");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Command 0x85 with a latency measurement on the second nibble
    exp_q.push_back('{1'b0, 8'h85, 1'b0, model_byte(1'b0, 8'h85)});
    send_nibble(1'b0, 4'h8);
    LCD_D = 5'h05;
    LCD_E = 1'b1;
    repeat (3) @(negedge CLK);
    LCD_E = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      if (byte_valid) begin
        lat = k;
        break;
      end
    end
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("FAIL latency got %0d want 4", lat);
    end
    repeat (6) @(negedge CLK);
    send_pair(1'b1, 4'h4, 1'b1, 4'h1);
    check_lines("char_at_col5");

    // Line 2 fill, completion pulse on the last column only, then an overflow byte is dropped
    send_pair(1'b0, 4'hC, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) send_pair(1'b1, 4'h3, 1'b1, 4'(i));
    send_pair(1'b1, 4'h5, 1'b1, 4'h8);
    check_lines("line2_fill");

    // RS mismatch between nibbles, then a good pair
    send_pair(1'b1, 4'h4, 1'b0, 4'h1);
    send_pair(1'b0, 4'h8, 1'b0, 4'h3);
    send_pair(1'b1, 4'h6, 1'b1, 4'h1);
    check_lines("after_mismatch");

    // Clear, then the first character lands at line 1 column 0
    send_pair(1'b0, 4'h0, 1'b0, 4'h1);
    check_lines("clear");
    send_pair(1'b1, 4'h7, 1'b1, 4'hA);
    check_lines("after_clear");

    // Randomized mix of addresses, commands, text and mismatches
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        if ($urandom_range(0, 1) != 0)
          b = 8'h80 | ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h00) | 8'($urandom_range(0, LL - 1));
        else
          b = 8'h80 | 8'($urandom_range(0, 127));
        send_pair(1'b0, b[7:4], 1'b0, b[3:0]);
      end else if (r < 25) begin
        send_pair(1'b0, 4'h0, 1'b0, 4'h1);
      end else if (r < 32) begin
        rh = 1'($urandom_range(0, 1));
        send_pair(rh, 4'($urandom_range(0, 15)), ~rh, 4'($urandom_range(0, 15)));
      end else if (r < 37) begin
        b = 8'($urandom_range(2, 127));
        send_pair(1'b0, b[7:4], 1'b0, b[3:0]);
      end else begin
        b = 8'($urandom_range(32, 126));
        send_pair(1'b1, b[7:4], 1'b1, b[3:0]);
      end
      check_lines("random");
    end

`ifdef LCD_RX_TIMEOUT_EN
    // Lone high nibble times out; the next pair is a fresh byte
    exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
    send_nibble(1'b1, 4'h7);
    repeat (5010) @(negedge CLK);
    send_pair(1'b0, 4'h8, 1'b0, 4'h0);
    send_pair(1'b1, 4'h4, 1'b1, 4'h3);
    check_lines("after_timeout");
`endif

    // Reset between nibbles discards the half byte
    send_pair(1'b1, 4'h5, 1'b1, 4'hA);
    drain("pre_reset");
    send_nibble(1'b1, 4'h9);
    RESET = 1'b1;
    #2;
    model_reset();
    check_reset_outs("mid_byte_reset");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    send_pair(1'b1, 4'h4, 1'b1, 4'h2);
    check_lines("after_reset");

    drain("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
